// File: rtl/sclkfifo_if.sv
// sclkfifo_if: handshake/data bundle for the sclkfifo single-clock FIFO.
//
// Parameters: WIDTH (data word bits), LOG2_DEPTH (log2 of entry count).
// Signals:
//   ren, rdata, rempty, raempty       read side (show-ahead head word)
//   wen, wdata, wfull, wafull         write side
//   level                             occupancy 0..2**LOG2_DEPTH
//   overflow, underflow               sticky error flags (0 unless enabled)
// Modports:
//   master - the surrounding producer/consumer logic (drives ren/wen/wdata)
//   slave  - the FIFO itself
interface sclkfifo_if #(
  parameter int WIDTH      = 32,
  parameter int LOG2_DEPTH = 4
);
  logic                  ren;
  logic [WIDTH-1:0]      rdata;
  logic                  rempty;
  logic                  raempty;
  logic                  wen;
  logic [WIDTH-1:0]      wdata;
  logic                  wfull;
  logic                  wafull;
  logic [LOG2_DEPTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output ren, wen, wdata,
    input  rdata, rempty, raempty, wfull, wafull, level, overflow, underflow
  );

  modport slave (
    input  ren, wen, wdata,
    output rdata, rempty, raempty, wfull, wafull, level, overflow, underflow
  );
endinterface

// File: rtl/sclkfifo.sv
// sclkfifo: single-clock FIFO with power-of-two depth and show-ahead read.
//
// The head word is kept in a register (rdata) so it is valid whenever rempty
// is low; asserting ren pops it. All status outputs are registered and are
// derived from the occupancy the FIFO will have after the current edge.
//
// Ports:
//   clk   in  rising-edge clock
//   arst  in  asynchronous, active-high reset
//   fif   sclkfifo_if.slave  (ren/rdata/rempty/raempty, wen/wdata/wfull/
//         wafull, level, overflow/underflow)
//
// Parameters: WIDTH, LOG2_DEPTH, AFULL_LEVEL (wafull when level >= it),
//             AEMPTY_LEVEL (raempty when level <= it).
//
// Build option: define SCLKFIFO_ERR_FLAGS_EN to enable the sticky overflow /
// underflow flags; otherwise they are tied low and no logic is built.
module sclkfifo #(
  parameter int WIDTH        = 32,
  parameter int LOG2_DEPTH   = 4,
  parameter int AFULL_LEVEL  = 2**LOG2_DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic        clk,
  input  logic        arst,
  sclkfifo_if.slave   fif
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int LW    = LOG2_DEPTH + 1;

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);
  localparam logic [LW-1:0] ONE_L    = LW'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE = LOG2_DEPTH'(1);

  // Storage is deliberately not reset.
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic [LOG2_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG2_DEPTH-1:0] rptr_q, rptr_d;
  logic [LOG2_DEPTH-1:0] rptr_nxt;
  logic [LW-1:0]         level_q, level_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rempty_q, rempty_d;
  logic                  raempty_q, raempty_d;
  logic                  wfull_q, wfull_d;
  logic                  wafull_q, wafull_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  bypass;

  always_comb begin
    // A write on a full FIFO is still taken when the head is popped in the
    // same cycle; a read on an empty FIFO is never taken.
    wr_acc   = fif.wen & (~wfull_q | fif.ren);
    rd_acc   = fif.ren & ~rempty_q;

    rptr_nxt = rptr_q + PTR_ONE;
    wptr_d   = wr_acc ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d   = rd_acc ? rptr_nxt : rptr_q;

    level_d  = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + ONE_L;
      2'b01:   level_d = level_q - ONE_L;
      default: level_d = level_q;
    endcase

    // The incoming word becomes the head when nothing else will be stored
    // after this edge: FIFO empty, or its single word is leaving now.
    bypass  = wr_acc & ((level_q == '0) | ((level_q == ONE_L) & rd_acc));

    rdata_d = rdata_q;
    if (bypass) begin
      rdata_d = fif.wdata;
    end else if (rd_acc) begin
      rdata_d = mem_q[rptr_nxt];
    end

    rempty_d  = (level_d == '0);
    wfull_d   = (level_d == DEPTH_L);
    wafull_d  = (level_d >= AFULL_L);
    raempty_d = (level_d <= AEMPTY_L);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= fif.wdata;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      rdata_q   <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      wfull_q   <= 1'b0;
      wafull_q  <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      rdata_q   <= rdata_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      wfull_q   <= wfull_d;
      wafull_q  <= wafull_d;
    end
  end

  assign fif.rdata   = rdata_q;
  assign fif.rempty  = rempty_q;
  assign fif.raempty = raempty_q;
  assign fif.wfull   = wfull_q;
  assign fif.wafull  = wafull_q;
  assign fif.level   = level_q;

`ifdef SCLKFIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky until reset; they record the attempt, the dropped/ignored
  // operation itself behaves exactly as in the build without flags.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (fif.wen & wfull_q & ~fif.ren) begin
        overflow_q <= 1'b1;
      end
      if (fif.ren & rempty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign fif.overflow  = overflow_q;
  assign fif.underflow = underflow_q;
`else
  assign fif.overflow  = 1'b0;
  assign fif.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sclkfifo.sv
// tb_sclkfifo: directed bench for sclkfifo (depth 4, afull 3, aempty 1).
// A queue-based model of the FIFO contents is compared with the DUT outputs
// on every falling clock edge; hand-computed literals pin key points.
module tb_sclkfifo;

  localparam int W  = 8;
  localparam int LD = 2;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int AEMPTY = 1;
`ifdef SCLKFIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic arst;

  sclkfifo_if #(.WIDTH(W), .LOG2_DEPTH(LD)) bus ();

  sclkfifo #(
    .WIDTH(W), .LOG2_DEPTH(LD), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .clk (clk),
    .arst(arst),
    .fif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  logic [W-1:0] mq [$];
  bit exp_ovf = 1'b0;
  bit exp_unf = 1'b0;
  bit last_wr = 1'b0;
  bit last_rd = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: one clock edge of a FIFO of DEPTH words.
  task automatic model_step(input bit w, input logic [W-1:0] d, input bit r);
    int sz;
    sz = mq.size();
    last_rd = r && (sz > 0);
    last_wr = w && ((sz < DEPTH) || r);
    if (ERR_EN && w && (sz == DEPTH) && !r) exp_ovf = 1'b1;
    if (ERR_EN && r && (sz == 0)) exp_unf = 1'b1;
    if (last_rd) void'(mq.pop_front());
    if (last_wr) mq.push_back(d);
  endtask

  task automatic cycle(input bit w, input logic [W-1:0] d, input bit r);
    @(negedge clk);
    #1;
    bus.wen   = w;
    bus.wdata = d;
    bus.ren   = r;
    @(posedge clk);
    model_step(w, d, r);
    #1;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
  endtask

  // Asserts reset between clock edges and checks outputs without any edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    arst = 1'b1;
    mq.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    chk("rst_rempty",  bus.rempty,  1);
    chk("rst_raempty", bus.raempty, 1);
    chk("rst_wfull",   bus.wfull,   0);
    chk("rst_wafull",  bus.wafull,  0);
    chk("rst_level",   bus.level,   0);
    chk("rst_rdata",   bus.rdata,   0);
    chk("rst_ovf",     bus.overflow,  0);
    chk("rst_unf",     bus.underflow, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    arst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_rempty",  bus.rempty,  mq.size() == 0);
      chk("m_wfull",   bus.wfull,   mq.size() == DEPTH);
      chk("m_wafull",  bus.wafull,  mq.size() >= AFULL);
      chk("m_raempty", bus.raempty, mq.size() <= AEMPTY);
      chk("m_level",   bus.level,   mq.size());
      chk("m_ovf",     bus.overflow,  exp_ovf);
      chk("m_unf",     bus.underflow, exp_unf);
      if (mq.size() != 0) chk("m_rdata", bus.rdata, mq[0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int got;
    int n;
    arst = 1'b1;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    arst = 1'b0;
    chk_on = 1'b1;

    // Reset mid-operation with data stored.
    cycle(1, 8'h5A, 0);
    cycle(1, 8'h6B, 0);
    chk("pre_rst_rdata", bus.rdata, 8'h5A);
    do_reset();

    // Fill / drain.
    for (int i = 1; i <= 4; i++) cycle(1, W'(i), 0);
    chk("fill_wfull", bus.wfull, 1);
    chk("fill_level", bus.level, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_rdata", bus.rdata, i);
      cycle(0, 8'h00, 1);
    end
    chk("drain_rempty", bus.rempty, 1);

    // Empty with write and read together: write only.
    cycle(1, 8'hA5, 1);
    chk("er_rempty", bus.rempty, 0);
    chk("er_level",  bus.level, 1);
    chk("er_rdata",  bus.rdata, 8'hA5);
    cycle(1, 8'hB6, 1);
    chk("pop1_bypass", bus.rdata, 8'hB6);
    cycle(0, 8'h00, 1);

    // Full with write and read together.
    for (int i = 0; i < 4; i++) cycle(1, W'(8'h10 + i), 0);
    cycle(1, 8'h14, 1);
    chk("fr_level", bus.level, 4);
    chk("fr_wfull", bus.wfull, 1);
    chk("fr_rdata", bus.rdata, 8'h11);
    repeat (3) cycle(0, 8'h00, 1);
    chk("fr_tail", bus.rdata, 8'h14);
    cycle(0, 8'h00, 1);

    // Thresholds.
    cycle(1, 8'h21, 0);
    chk("th_raempty1", bus.raempty, 1);
    cycle(1, 8'h22, 0);
    chk("th_raempty2", bus.raempty, 0);
    chk("th_wafull2",  bus.wafull, 0);
    cycle(1, 8'h23, 0);
    chk("th_wafull3",  bus.wafull, 1);
    cycle(0, 8'h00, 1);
    chk("th_wafull_dn", bus.wafull, 0);
    cycle(0, 8'h00, 1);
    chk("th_raempty_up", bus.raempty, 1);
    cycle(0, 8'h00, 1);

    // Random stream of 20 words.
    sent = 0;
    got = 0;
    n = 0;
    while (got < 20 && n < 400) begin
      cycle((sent < 20) && ($urandom_range(0, 3) != 0), W'(8'h40 + sent),
            $urandom_range(0, 2) != 0);
      if (last_wr) sent++;
      if (last_rd) got++;
      n++;
    end
    chk("stream_count", got, 20);

    // Error flags: overflow drops the word, underflow on empty read.
    for (int i = 0; i < 4; i++) cycle(1, W'(8'h70 + i), 0);
    cycle(1, 8'h99, 0);
    chk("ovf_lit",   bus.overflow, ERR_EN);
    chk("ovf_level", bus.level, 4);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_rdata", bus.rdata, 8'h70 + i);
      cycle(0, 8'h00, 1);
    end
    cycle(0, 8'h00, 1);
    chk("unf_lit",   bus.underflow, ERR_EN);
    chk("unf_level", bus.level, 0);
    cycle(1, 8'h55, 0);
    cycle(0, 8'h00, 1);
    chk("ovf_sticky", bus.overflow, ERR_EN);
    chk("unf_sticky", bus.underflow, ERR_EN);
    do_reset();
    cycle(0, 8'h00, 0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
